// File: rtl/cache_port_arbiter.sv
// Shares one single-ported byte-addressable cache between IF and LSU.
// Optional macro ARB_RR_EN selects round-robin arbitration.
//
// Ports:
//   clk, rst                         clock, sync active-high reset
//   if_req_valid/ready, if_addr      fetch request (always LW)
//   if_rsp_valid/err, if_rdata       registered fetch response pulse
//   lsu_req_valid/ready, lsu_we,
//   lsu_addr, lsu_wdata, lsu_strobe,
//   lsu_load_type                    load/store request
//   lsu_rsp_valid/err, lsu_rdata     registered load/store response pulse
//   c_addr, c_wdata, c_strobe,
//   c_write_en, c_read_en,
//   c_load_type, c_rdata             cache port (one access cycle)
module cache_port_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_rsp_valid,
  output logic                  if_rsp_err,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic                  lsu_we,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [3:0]            lsu_strobe,
  input  logic [2:0]            lsu_load_type,
  output logic                  lsu_rsp_valid,
  output logic                  lsu_rsp_err,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic [ADDR_WIDTH-1:0] c_addr,
  output logic [DATA_WIDTH-1:0] c_wdata,
  output logic [3:0]            c_strobe,
  output logic                  c_write_en,
  output logic                  c_read_en,
  output logic [2:0]            c_load_type,
  input  logic [DATA_WIDTH-1:0] c_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t                state;
  logic                  own_lsu;
  logic                  lat_err;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [3:0]            lat_strobe;
  logic [2:0]            lat_lt;

  logic idle;
  logic if_wins;
  logic gnt_if;
  logic gnt_lsu;
  logic if_err;
  logic ld_err;
  logic st_err;
  logic lsu_err;

`ifdef ARB_RR_EN
  // 1 when the LSU was granted last; IF then wins a conflict.
  logic rr_last;
  assign if_wins = rr_last;
`else
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  logic [CW-1:0] starve_cnt;
  assign if_wins = (starve_cnt == LIM);
`endif

  assign idle    = (state == IDLE) && !rst;
  assign gnt_if  = idle && if_req_valid
                && (!lsu_req_valid || if_wins);
  assign gnt_lsu = idle && lsu_req_valid
                && (!if_req_valid || !if_wins);

  assign if_req_ready  = gnt_if;
  assign lsu_req_ready = gnt_lsu;

  assign if_err = |if_addr[1:0];

  always_comb begin
    ld_err = 1'b1;
    unique case (1'b1)
      lsu_load_type == 3'b000,
      lsu_load_type == 3'b001: ld_err = 1'b0;
      lsu_load_type == 3'b010,
      lsu_load_type == 3'b011: ld_err = lsu_addr[0];
      lsu_load_type == 3'b100: ld_err = |lsu_addr[1:0];
      default:                 ld_err = 1'b1;
    endcase
  end

  assign st_err = (lsu_strobe == 4'b0000)
               || (lsu_strobe == 4'b1111 && |lsu_addr[1:0])
               || (lsu_strobe == 4'b0011 && lsu_addr[0]);

  assign lsu_err = lsu_we ? st_err : ld_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      own_lsu       <= 1'b0;
      lat_err       <= 1'b0;
      lat_we        <= 1'b0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      lat_strobe    <= '0;
      lat_lt        <= '0;
      if_rsp_valid  <= 1'b0;
      if_rsp_err    <= 1'b0;
      if_rdata      <= '0;
      lsu_rsp_valid <= 1'b0;
      lsu_rsp_err   <= 1'b0;
      lsu_rdata     <= '0;
`ifdef ARB_RR_EN
      rr_last       <= 1'b0;
`else
      starve_cnt    <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_if) begin
            own_lsu    <= 1'b0;
            lat_err    <= if_err;
            lat_we     <= 1'b0;
            lat_addr   <= if_addr;
            lat_wdata  <= '0;
            lat_strobe <= '0;
            lat_lt     <= 3'b100;
            state      <= ACCESS;
          end else if (gnt_lsu) begin
            own_lsu    <= 1'b1;
            lat_err    <= lsu_err;
            lat_we     <= lsu_we;
            lat_addr   <= lsu_addr;
            lat_wdata  <= lsu_wdata;
            lat_strobe <= lsu_strobe;
            lat_lt     <= lsu_load_type;
            state      <= ACCESS;
          end
`ifdef ARB_RR_EN
          if (gnt_if) rr_last <= 1'b0;
          else if (gnt_lsu) rr_last <= 1'b1;
`else
          if (gnt_if)
            starve_cnt <= '0;
          else if (gnt_lsu && if_req_valid
                   && starve_cnt != LIM)
            starve_cnt <= starve_cnt + 1'b1;
`endif
        end
        ACCESS: begin
          if (own_lsu) begin
            lsu_rsp_valid <= 1'b1;
            lsu_rsp_err   <= lat_err;
            lsu_rdata     <= (lat_err || lat_we)
                             ? '0 : c_rdata;
          end else begin
            if_rsp_valid <= 1'b1;
            if_rsp_err   <= lat_err;
            if_rdata     <= lat_err ? '0 : c_rdata;
          end
          state <= RESP;
        end
        RESP: begin
          if_rsp_valid  <= 1'b0;
          if_rsp_err    <= 1'b0;
          lsu_rsp_valid <= 1'b0;
          lsu_rsp_err   <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic acc;
  assign acc = (state == ACCESS);

  assign c_addr      = acc ? lat_addr   : '0;
  assign c_wdata     = acc ? lat_wdata  : '0;
  assign c_strobe    = acc ? lat_strobe : '0;
  assign c_load_type = acc ? lat_lt     : '0;
  assign c_write_en  = acc && lat_we  && !lat_err;
  assign c_read_en   = acc && !lat_we && !lat_err;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: cache memory model plus
// a byte-array reference of the expected memory contents.
module tb_cache_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [9:0]  if_addr;
  logic        if_rsp_valid;
  logic        if_rsp_err;
  logic [31:0] if_rdata;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_we;
  logic [9:0]  lsu_addr;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_strobe;
  logic [2:0]  lsu_load_type;
  logic        lsu_rsp_valid;
  logic        lsu_rsp_err;
  logic [31:0] lsu_rdata;
  logic [9:0]  c_addr;
  logic [31:0] c_wdata;
  logic [3:0]  c_strobe;
  logic        c_write_en;
  logic        c_read_en;
  logic [2:0]  c_load_type;
  logic [31:0] c_rdata;

  int checks = 0;
  int errors = 0;
  int wr_cycles = 0;
  int rd_cycles = 0;
  logic preload;
  logic last_lsu;

  cache_port_arbiter #(
    .ADDR_WIDTH(10),
    .DATA_WIDTH(32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
    .if_addr(if_addr), .if_rsp_valid(if_rsp_valid),
    .if_rsp_err(if_rsp_err), .if_rdata(if_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_strobe(lsu_strobe), .lsu_load_type(lsu_load_type),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_err(lsu_rsp_err),
    .lsu_rdata(lsu_rdata), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_strobe(c_strobe), .c_write_en(c_write_en),
    .c_read_en(c_read_en), .c_load_type(c_load_type),
    .c_rdata(c_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache: byte array, combinational read, write at the edge.
  logic [7:0] mem [0:1023];
  logic [7:0] ref_mem [0:1023];

  function automatic logic [7:0] pat(int i);
    return 8'(i * 37 + 5);
  endfunction

  function automatic logic [31:0] ext(logic [31:0] w,
                                      logic [2:0] lt);
    case (lt)
      3'd0:    return {{24{w[7]}}, w[7:0]};
      3'd1:    return {24'b0, w[7:0]};
      3'd2:    return {{16{w[15]}}, w[15:0]};
      3'd3:    return {16'b0, w[15:0]};
      default: return w;
    endcase
  endfunction

  logic [31:0] c_word;
  assign c_word = {mem[c_addr + 10'd3], mem[c_addr + 10'd2],
                   mem[c_addr + 10'd1], mem[c_addr]};
  assign c_rdata = c_read_en ? ext(c_word, c_load_type) : 32'd0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
    end else if (c_write_en) begin
      for (int i = 0; i < 4; i++)
        if (c_strobe[i])
          mem[c_addr + 10'(i)] <= c_wdata[8*i +: 8];
    end
  end

  always @(negedge clk) begin
    if (c_write_en) wr_cycles++;
    if (c_read_en) rd_cycles++;
  end

  // Reference model: spec rules on plain arrays.
  function automatic logic m_err(logic is_if, logic we,
      logic [9:0] a, logic [3:0] s, logic [2:0] lt);
    if (is_if) return a[1:0] != 2'd0;
    if (we) return s == 4'd0 || (s == 4'hF && a[1:0] != 2'd0)
                || (s == 4'h3 && a[0]);
    case (lt)
      3'd0, 3'd1: return 1'b0;
      3'd2, 3'd3: return a[0];
      3'd4:       return a[1:0] != 2'd0;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] m_load(logic [9:0] a,
                                         logic [2:0] lt);
    logic [31:0] w;
    w = {ref_mem[a + 10'd3], ref_mem[a + 10'd2],
         ref_mem[a + 10'd1], ref_mem[a]};
    return ext(w, lt);
  endfunction

  task automatic m_store(logic [9:0] a, logic [31:0] wd,
                         logic [3:0] s);
    for (int i = 0; i < 4; i++)
      if (s[i]) ref_mem[a + 10'(i)] = wd[8*i +: 8];
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic is_if, input logic we,
      input logic [9:0] a, input logic [31:0] wd,
      input logic [3:0] s, input logic [2:0] lt,
      input string tag, output logic [31:0] got);
    logic e;
    logic [31:0] exp;
    logic rdy;
    int n;
    e = m_err(is_if, is_if ? 1'b0 : we, a, s, lt);
    exp = (e || (we && !is_if)) ? 32'd0
        : m_load(a, is_if ? 3'd4 : lt);
    got = 32'd0;
    if (is_if) begin
      if_addr = a;
      if_req_valid = 1'b1;
    end else begin
      lsu_we = we;
      lsu_addr = a;
      lsu_wdata = wd;
      lsu_strobe = s;
      lsu_load_type = lt;
      lsu_req_valid = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk);
      rdy = is_if ? if_req_ready : lsu_req_ready;
      n++;
    end while (!rdy && n < 20);
    chk({tag, "_ready"}, 32'(rdy), 32'd1);
    if (!rdy) begin
      if_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    last_lsu = !is_if;
    @(negedge clk);
    chk({tag, "_wen"}, 32'(c_write_en),
        32'(!is_if && we && !e));
    chk({tag, "_ren"}, 32'(c_read_en),
        32'(!(!is_if && we) && !e));
    @(negedge clk);
    if (is_if) begin
      chk({tag, "_vld"}, 32'(if_rsp_valid), 32'd1);
      chk({tag, "_err"}, 32'(if_rsp_err), 32'(e));
      chk({tag, "_data"}, if_rdata, exp);
      got = if_rdata;
    end else begin
      chk({tag, "_vld"}, 32'(lsu_rsp_valid), 32'd1);
      chk({tag, "_err"}, 32'(lsu_rsp_err), 32'(e));
      chk({tag, "_data"}, lsu_rdata, exp);
      got = lsu_rdata;
      if (we && !e) m_store(a, wd, s);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(string tag);
    chk({tag, "_ctl"},
        32'({if_req_ready, lsu_req_ready, if_rsp_valid,
             lsu_rsp_valid, if_rsp_err, lsu_rsp_err,
             c_write_en, c_read_en}), 32'd0);
    chk({tag, "_dat"},
        if_rdata | lsu_rdata | c_wdata | 32'(c_addr)
        | 32'(c_strobe) | 32'(c_load_type), 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    logic g_lsu;
    logic exp_lsu;
    logic rdy;
    int w0;
    int r0;
    int n;
    rst = 1'b1;
    preload = 1'b1;
    if_req_valid = 1'b0;
    if_addr = '0;
    lsu_req_valid = 1'b0;
    lsu_we = 1'b0;
    lsu_addr = '0;
    lsu_wdata = '0;
    lsu_strobe = '0;
    lsu_load_type = '0;
    last_lsu = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    preload = 1'b0;
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk);
    #1;

    txn(0, 1, 10'h10, 32'hDEADBEEF, 4'hF, 3'd4, "st_dead", got);
    txn(1, 0, 10'h10, 32'd0, 4'h0, 3'd4, "if_dead", got);
    chk("if_dead_const", got, 32'hDEADBEEF);

    txn(0, 1, 10'h10, 32'h0000FF80, 4'h3, 3'd4, "st_h", got);
    txn(0, 0, 10'h10, 32'd0, 4'h0, 3'd0, "lb", got);
    chk("lb_const", got, 32'hFFFFFF80);
    txn(0, 0, 10'h10, 32'd0, 4'h0, 3'd1, "lbu", got);
    chk("lbu_const", got, 32'h00000080);
    txn(0, 0, 10'h10, 32'd0, 4'h0, 3'd2, "lh", got);
    chk("lh_const", got, 32'hFFFFFF80);
    txn(0, 0, 10'h10, 32'd0, 4'h0, 3'd3, "lhu", got);
    chk("lhu_const", got, 32'h0000FF80);

    w0 = wr_cycles;
    r0 = rd_cycles;
    txn(0, 0, 10'h13, 32'd0, 4'h0, 3'd4, "lw_mis", got);
    txn(0, 1, 10'h10, 32'h11111111, 4'h0, 3'd4, "st_s0", got);
    txn(1, 0, 10'h12, 32'd0, 4'h0, 3'd4, "if_mis", got);
    chk("err_no_access", 32'((wr_cycles - w0) + (rd_cycles - r0)),
        32'd0);
    txn(0, 0, 10'h10, 32'd0, 4'h0, 3'd4, "mem_kept", got);
    chk("mem_kept_const", got, 32'hDEADFF80);

    w0 = wr_cycles;
    txn(0, 1, 10'h20, 32'hAABBCCDD, 4'b0100, 3'd4, "st_b", got);
    chk("st_b_wcyc", 32'(wr_cycles - w0), 32'd1);
    chk("st_b_byte", 32'(mem[10'h22]), 32'hBB);
    chk("st_b_word",
        {mem[10'h23], mem[10'h22], mem[10'h21], mem[10'h20]},
        {pat(35), 8'hBB, pat(33), pat(32)});

    for (int k = 0; k < 30; k++) begin
      txn(1'($urandom_range(0, 2) == 0), 1'($urandom),
          10'($urandom), $urandom, 4'($urandom),
          3'($urandom), $sformatf("rnd%0d", k), got);
    end

    // Both requesters held valid: check the grant sequence.
    if_addr = 10'h10;
    lsu_we = 1'b0;
    lsu_addr = 10'h20;
    lsu_load_type = 3'd4;
    if_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        rdy = if_req_ready | lsu_req_ready;
        n++;
      end while (!rdy && n < 20);
      chk($sformatf("arb%0d_one", k),
          32'({if_req_ready, lsu_req_ready}),
          lsu_req_ready ? 32'd1 : 32'd2);
      g_lsu = lsu_req_ready;
`ifdef ARB_RR_EN
      exp_lsu = !last_lsu;
`else
      exp_lsu = (k % 5) != 4;
`endif
      chk($sformatf("arb%0d_lsu", k), 32'(g_lsu), 32'(exp_lsu));
      last_lsu = g_lsu;
      @(posedge clk);
      #1;
    end
    if_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset during the ACCESS cycle of a store.
    lsu_we = 1'b1;
    lsu_addr = 10'h40;
    lsu_wdata = 32'h12345678;
    lsu_strobe = 4'hF;
    lsu_load_type = 3'd4;
    lsu_req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lsu_req_ready && n < 20);
    chk("rst_st_ready", 32'(lsu_req_ready), 32'd1);
    @(posedge clk);
    #1;
    lsu_req_valid = 1'b0;
    @(negedge clk);
    chk("rst_st_wen", 32'(c_write_en), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_store(10'h40, 32'h12345678, 4'hF);
    last_lsu = 1'b0;
    @(negedge clk);
    chk_quiet("rst_mid");
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (lsu_rsp_valid || if_rsp_valid) n++;
    end
    chk("rst_no_rsp", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    txn(0, 0, 10'h40, 32'd0, 4'h0, 3'd4, "after_rst", got);
    txn(1, 0, 10'h20, 32'd0, 4'h0, 3'd4, "after_rst_if", got);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Shares the single-ported unified byte-addressable cache between the instruction-fetch (IF) and load/store (LSU) requesters.
- Accepts one request at a time over valid/ready handshakes and drives the cache for exactly one cycle.
- Returns read data, or a store acknowledge, through a registered one-cycle response pulse.
- Sits between the core front-end/LSU and the cache; checks alignment; prevents IF starvation.

Parameters:
ADDR_WIDTH, 10, cache byte-address width
DATA_WIDTH, 32, data width (fixed 32; load_type encoding assumes it)
STARVE_LIMIT, 4, consecutive IF losses before IF is forced to win

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_req_valid  in  1  IF request
if_req_ready  out  1  IF request accepted this cycle
if_addr  in  ADDR_WIDTH  fetch byte address (always LW)
if_rsp_valid  out  1  one-cycle IF response pulse
if_rsp_err  out  1  misaligned fetch, valid with if_rsp_valid
if_rdata  out  32  fetched word
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_we  in  1  1=store, 0=load
lsu_addr  in  ADDR_WIDTH  byte address
lsu_wdata  in  32  store data
lsu_strobe  in  4  store byte enables
lsu_load_type  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW
lsu_rsp_valid  out  1  one-cycle LSU response pulse (loads and stores)
lsu_rsp_err  out  1  misaligned/illegal access
lsu_rdata  out  32  load result; 0 for stores and errors
c_addr  out  ADDR_WIDTH  cache address
c_wdata  out  32  cache write data
c_strobe  out  4  cache byte enables
c_write_en  out  1  cache write
c_read_en  out  1  cache read
c_load_type  out  3  cache load type
c_rdata  in  32  cache combinational read data

Behaviour:
- Reset: FSM=IDLE, starve_cnt=0, rr_last=IF. All outputs 0, including both readies, both rsp_valids, errs, rdatas and every c_* output.
- FSM states:
  - IDLE: readies are combinational from the valids. Arbitrate; on a grant, latch the request fields, owner and err flag, then go to ACCESS.
  - ACCESS: drive the c_* outputs from the latched fields for exactly this cycle. At this cycle's clock edge, register c_rdata (or 0) into the owner's rdata, then go to RESP.
  - RESP: assert the owner's rsp_valid and rsp_err for this cycle only, then go to IDLE.
- Timing:
  - A request accepted at edge N has c_*_en high during cycle N+1 and rsp_valid high during cycle N+2.
  - The next acceptance is at edge N+3, giving throughput of 1 request per 3 cycles.
- Ready rules:
  - ready is high only in IDLE, for the granted requester only.
  - A requester must hold valid and its fields stable until ready; the requester with ready low holds.
  - Both readies are low in ACCESS and RESP regardless of the valids.
- Arbitration (default, fixed priority):
  - LSU wins a conflict unless starve_cnt==STARVE_LIMIT, in which case IF wins.
  - starve_cnt increments on each IDLE cycle where IF is valid and loses. It saturates at STARVE_LIMIT.
  - starve_cnt clears to 0 when IF is granted.
- Alignment (err=1 suppresses the cache access):
  - Under err, c_read_en and c_write_en stay 0 in ACCESS, rdata=0, and the response still occurs at N+2.
  - IF: err if if_addr[1:0]!=0.
  - LSU load: err if LH/LHU with addr[0]!=0, LW with addr[1:0]!=0, or load_type in {101,110,111}.
  - LSU store: err if strobe==0, strobe==1111 with addr[1:0]!=0, or strobe==0011 with addr[0]!=0.
- Cache drive:
  - IF reads use c_load_type=100 and c_strobe=0.
  - Stores use c_write_en=1, c_read_en=0, and c_load_type=latched value.
  - Loads use c_read_en=1 and c_write_en=0.
  - Outside ACCESS, every c_* output is 0.
- Stores: lsu_rsp_valid pulses with lsu_rdata=0 as the write acknowledge.
- Reset mid-operation: an in-flight transaction is dropped with no response. If reset is asserted during ACCESS, c_write_en is low from the next cycle on.
- rdata holds its last value between responses; only the rsp_valid qualifier matters.

Optional Feature:
ARB_RR_EN:
- Defined: conflicts are resolved round-robin. The requester not granted last (rr_last) wins, and rr_last updates on every grant. starve_cnt is removed and STARVE_LIMIT is ignored.
- Undefined: fixed LSU priority with the starvation counter as described above.

Test Plan:
- Single IF fetch: write 0xDEADBEEF at addr 0x10 via LSU, then IF fetch 0x10. Required: if_rsp_valid 2 cycles after the accept, if_rdata=0xDEADBEEF, err=0.
- LSU LB/LBU/LH/LHU at 0x10 with byte0=0x80, byte1=0xFF. Required: LB 0xFFFFFF80, LBU 0x00000080, LH 0xFFFFFF80, LHU 0x0000FF80.
- Both valid continuously, default build, STARVE_LIMIT=4. Required: grants LSU, LSU, LSU, LSU, IF, LSU…; no IF wait exceeds 4 losses. With ARB_RR_EN the grants alternate.
- Misaligned LW at 0x13, and a store with strobe=0. Required: lsu_rsp_err=1, rdata=0, c_read_en and c_write_en never high, memory unchanged.
- Store strobe=0100, wdata=0xAABBCCDD at 0x20. Required: c_write_en high exactly 1 cycle and only byte 0x22 becomes 0xBB.
- Reset asserted during ACCESS of a store. Required: no rsp_valid; all outputs 0 the cycle after; the next request completes normally.
